// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode constants, ALU/PC mux encodings and the bundled datapath control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecute  = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StAddiEx   = 4'd11,
    StAddiWb   = 4'd12,
    StTrap     = 4'd13
  } state_e;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] ADDI   = 6'h08;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluBReg     = 2'b00;
  localparam logic [1:0] AluBFour    = 2'b01;
  localparam logic [1:0] AluBImm     = 2'b10;
  localparam logic [1:0] AluBImmSh2  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and its datapath.
//   master: control unit side (samples run/opcode/mem_ready, drives controls + status)
//   slave : datapath / environment side
interface multicycle_control_unit_if;
  logic        run;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        pc_write;
  logic        pc_write_cond;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dest;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_source;

  logic [3:0]  state;
  logic        instr_done;
  logic        illegal_op;
  logic [31:0] retire_count;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, illegal_op, retire_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, illegal_op, retire_count
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control decode for the multicycle control unit.
//   state     : current FSM state
//   mem_ready : memory handshake; gates the IR/PC write during FETCH
//   ctrl      : datapath control word plus illegal_op status
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e   state,
  input  logic     mem_ready,
  output ctrl_t    ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = AluBFour;
        ctrl.alu_op    = AluOpAdd;
        ctrl.pc_source = PcSrcAlu;
        // IR and PC latch only on the cycle the instruction word arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = AluBImmSh2;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemAddr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluBImm;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StExecute: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluBReg;
        ctrl.alu_op    = AluOpFunct;
      end
      StRWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AluOpSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcJump;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      StTrap: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: FSM next-state logic, retire counter and
// output mapping. Controls are decoded from state in multicycle_ctrl_decode.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : run/opcode/mem_ready in; datapath controls, state, instr_done,
//           illegal_op and retire_count out
//   ILLEGAL_TRAP : 1 = unknown opcode traps and halts, 0 = treated as NOP
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] retire_q;
  logic        instr_done;
  ctrl_t       ctrl;

  always_comb begin
    state_d    = state_q;
    instr_done = 1'b0;
    case (state_q)
      StIdle:    if (bus.run) state_d = StFetch;
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          R_TYPE:  state_d = StExecute;
          LW, SW:  state_d = StMemAddr;
          BEQ:     state_d = StBranch;
          J:       state_d = StJump;
          ADDI:    state_d = StAddiEx;
          default: begin
            if (ILLEGAL_TRAP) state_d = StTrap;
            else              instr_done = 1'b1;
          end
        endcase
      end
      StMemAddr:  state_d = (bus.opcode == SW) ? StMemWrite : StMemRead;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWrite: instr_done = bus.mem_ready;
      StExecute:  state_d = StRWb;
      StAddiEx:   state_d = StAddiWb;
      StMemWb, StRWb, StBranch, StJump, StAddiWb: instr_done = 1'b1;
      StTrap:     state_d = StTrap;
      default:    state_d = StIdle;
    endcase
    // run is only looked at when an instruction retires (and in IDLE)
    if (instr_done) state_d = bus.run ? StFetch : StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) retire_q <= retire_q + 32'd1;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dest      = ctrl.reg_dest;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state         = state_q;
  assign bus.instr_done    = instr_done;
  assign bus.retire_count  = retire_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. dut traps on illegal opcodes,
// dut_nop treats them as NOPs. Each row of a table drives run/mem_ready/opcode/
// reset for one cycle and gives the state and outputs expected in that cycle.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if if0 ();
  multicycle_control_unit_if if1 ();

  multicycle_control_unit #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.master)
  );

  multicycle_control_unit #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02, OP_ADDI = 6'h08, OP_BAD = 6'h3F;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MADDR = 4'd3;
  localparam logic [3:0] S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_EXE = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_BR = 4'd9, S_JMP = 4'd10, S_AEX = 4'd11;
  localparam logic [3:0] S_AWB = 4'd12, S_TRAP = 4'd13;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dest, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}
  localparam logic [15:0] C_ZERO  = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_FETCH = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_FWAIT = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_DEC   = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] C_ADDR  = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_MRD   = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MWB   = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] C_MWR   = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_EXE   = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] C_RWB   = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] C_BR    = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_JMP   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [15:0] C_AWB   = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [17:0] exp;  // {illegal_op, instr_done, controls}
  } row_t;

  function automatic row_t row(input int rst, input int run, input int mr,
                               input logic [5:0] op, input logic [3:0] st,
                               input int ill, input int done, input logic [15:0] c);
    row_t r;
    r.rst = rst[0];
    r.run = run[0];
    r.mr  = mr[0];
    r.op  = op;
    r.st  = st;
    r.exp = {ill[0], done[0], c};
    return r;
  endfunction

  // Drive one cycle of inputs, capture outputs mid-cycle, then advance a clock.
  task automatic drive_row(input bit sel, input row_t r,
                           output logic [3:0] st, output logic [17:0] o);
    reset = r.rst;
    if (!sel) begin
      if0.run = r.run; if0.mem_ready = r.mr; if0.opcode = r.op;
    end else begin
      if1.run = r.run; if1.mem_ready = r.mr; if1.opcode = r.op;
    end
    #1;
    if (!sel) begin
      st = if0.state;
      o  = {if0.illegal_op, if0.instr_done, if0.pc_write, if0.pc_write_cond, if0.i_or_d,
            if0.mem_read, if0.mem_write, if0.ir_write, if0.mem_to_reg, if0.reg_dest,
            if0.reg_write, if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.pc_source};
    end else begin
      st = if1.state;
      o  = {if1.illegal_op, if1.instr_done, if1.pc_write, if1.pc_write_cond, if1.i_or_d,
            if1.mem_read, if1.mem_write, if1.ir_write, if1.mem_to_reg, if1.reg_dest,
            if1.reg_write, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.pc_source};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if0.run = 1'b0; if0.mem_ready = 1'b0; if0.opcode = OP_R;
    if1.run = 1'b0; if1.mem_ready = 1'b0; if1.opcode = OP_R;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    row_t t[2];
    logic [3:0] st;
    logic [17:0] o;
    do_reset();
    t[0] = row(0, 0, 1, OP_LW, S_IDLE, 0, 0, C_ZERO);
    t[1] = row(0, 0, 1, OP_LW, S_IDLE, 0, 0, C_ZERO);
    for (int i = 0; i < 2; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL reset[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL reset[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd0) begin
      miscompares++; $display("FAIL reset retire_count: got %0d want 0", if0.retire_count);
    end
    vectors++;
    if (if1.state !== S_IDLE) begin
      miscompares++; $display("FAIL reset nop-dut state: got %0d want 0", if1.state);
    end
  endtask

  task automatic test_lw();
    row_t t[7];
    logic [3:0] st;
    logic [17:0] o;
    t[0] = row(0, 1, 1, OP_LW, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 0, 1, OP_LW, S_FETCH, 0, 0, C_FETCH);
    t[2] = row(0, 0, 1, OP_LW, S_DEC,   0, 0, C_DEC);
    t[3] = row(0, 0, 1, OP_LW, S_MADDR, 0, 0, C_ADDR);
    t[4] = row(0, 0, 1, OP_LW, S_MRD,   0, 0, C_MRD);
    t[5] = row(0, 0, 1, OP_LW, S_MWB,   0, 1, C_MWB);
    t[6] = row(0, 0, 1, OP_LW, S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 7; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL lw[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL lw[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd1) begin
      miscompares++; $display("FAIL lw retire_count: got %0d want 1", if0.retire_count);
    end
  endtask

  task automatic test_sw_stall();
    row_t t[10];
    logic [3:0] st;
    logic [17:0] o;
    t[0] = row(0, 1, 0, OP_SW, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 0, 0, OP_SW, S_FETCH, 0, 0, C_FWAIT);
    t[2] = row(0, 0, 1, OP_SW, S_FETCH, 0, 0, C_FETCH);
    t[3] = row(0, 0, 1, OP_SW, S_DEC,   0, 0, C_DEC);
    t[4] = row(0, 0, 0, OP_SW, S_MADDR, 0, 0, C_ADDR);
    t[5] = row(0, 0, 0, OP_SW, S_MWR,   0, 0, C_MWR);
    t[6] = row(0, 0, 0, OP_SW, S_MWR,   0, 0, C_MWR);
    t[7] = row(0, 0, 0, OP_SW, S_MWR,   0, 0, C_MWR);
    t[8] = row(0, 0, 1, OP_SW, S_MWR,   0, 1, C_MWR);
    t[9] = row(0, 0, 0, OP_SW, S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 10; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL sw[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL sw[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd2) begin
      miscompares++; $display("FAIL sw retire_count: got %0d want 2", if0.retire_count);
    end
  endtask

  task automatic test_reset_priority();
    row_t t[7];
    logic [3:0] st;
    logic [17:0] o;
    t[0] = row(0, 1, 1, OP_LW, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 0, 1, OP_LW, S_FETCH, 0, 0, C_FETCH);
    t[2] = row(0, 0, 1, OP_LW, S_DEC,   0, 0, C_DEC);
    t[3] = row(0, 0, 1, OP_LW, S_MADDR, 0, 0, C_ADDR);
    t[4] = row(1, 0, 1, OP_LW, S_MRD,   0, 0, C_MRD);
    t[5] = row(0, 0, 1, OP_LW, S_IDLE,  0, 0, C_ZERO);
    t[6] = row(0, 0, 1, OP_LW, S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 7; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL rstprio[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL rstprio[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd0) begin
      miscompares++; $display("FAIL rstprio retire_count: got %0d want 0", if0.retire_count);
    end
  endtask

  task automatic test_back_to_back();
    row_t t[16];
    logic [3:0] st;
    logic [17:0] o;
    do_reset();
    t[0]  = row(0, 1, 1, OP_BEQ,  S_IDLE,  0, 0, C_ZERO);
    t[1]  = row(0, 1, 1, OP_BEQ,  S_FETCH, 0, 0, C_FETCH);
    t[2]  = row(0, 1, 1, OP_BEQ,  S_DEC,   0, 0, C_DEC);
    t[3]  = row(0, 1, 1, OP_BEQ,  S_BR,    0, 1, C_BR);
    t[4]  = row(0, 1, 1, OP_J,    S_FETCH, 0, 0, C_FETCH);
    t[5]  = row(0, 1, 1, OP_J,    S_DEC,   0, 0, C_DEC);
    t[6]  = row(0, 1, 1, OP_J,    S_JMP,   0, 1, C_JMP);
    t[7]  = row(0, 1, 1, OP_R,    S_FETCH, 0, 0, C_FETCH);
    t[8]  = row(0, 1, 1, OP_R,    S_DEC,   0, 0, C_DEC);
    t[9]  = row(0, 1, 1, OP_R,    S_EXE,   0, 0, C_EXE);
    t[10] = row(0, 1, 1, OP_R,    S_RWB,   0, 1, C_RWB);
    t[11] = row(0, 1, 1, OP_ADDI, S_FETCH, 0, 0, C_FETCH);
    t[12] = row(0, 1, 1, OP_ADDI, S_DEC,   0, 0, C_DEC);
    t[13] = row(0, 1, 1, OP_ADDI, S_AEX,   0, 0, C_ADDR);
    t[14] = row(0, 0, 1, OP_ADDI, S_AWB,   0, 1, C_AWB);
    t[15] = row(0, 0, 1, OP_ADDI, S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 16; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL b2b[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL b2b[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd4) begin
      miscompares++; $display("FAIL b2b retire_count: got %0d want 4", if0.retire_count);
    end
  endtask

  task automatic test_trap();
    row_t t[8];
    logic [3:0] st;
    logic [17:0] o;
    t[0] = row(0, 1, 1, OP_BAD, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 1, 1, OP_BAD, S_FETCH, 0, 0, C_FETCH);
    t[2] = row(0, 1, 1, OP_BAD, S_DEC,   0, 0, C_DEC);
    t[3] = row(0, 1, 1, OP_BAD, S_TRAP,  1, 0, C_ZERO);
    t[4] = row(0, 1, 1, OP_J,   S_TRAP,  1, 0, C_ZERO);
    t[5] = row(1, 1, 1, OP_J,   S_TRAP,  1, 0, C_ZERO);
    t[6] = row(0, 0, 1, OP_J,   S_IDLE,  0, 0, C_ZERO);
    t[7] = row(0, 0, 1, OP_J,   S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 8; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL trap[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL trap[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd0) begin
      miscompares++; $display("FAIL trap retire_count: got %0d want 0", if0.retire_count);
    end
  endtask

  task automatic test_nop();
    row_t t[8];
    logic [3:0] st;
    logic [17:0] o;
    t[0] = row(0, 1, 1, OP_BAD, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 1, 1, OP_BAD, S_FETCH, 0, 0, C_FETCH);
    t[2] = row(0, 1, 1, OP_BAD, S_DEC,   0, 1, C_DEC);
    t[3] = row(0, 0, 0, OP_BAD, S_FETCH, 0, 0, C_FWAIT);
    t[4] = row(0, 0, 1, OP_J,   S_FETCH, 0, 0, C_FETCH);
    t[5] = row(0, 0, 1, OP_J,   S_DEC,   0, 0, C_DEC);
    t[6] = row(0, 0, 1, OP_J,   S_JMP,   0, 1, C_JMP);
    t[7] = row(0, 0, 1, OP_J,   S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 8; i++) begin
      drive_row(1'b1, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL nop[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL nop[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if1.retire_count !== 32'd2) begin
      miscompares++; $display("FAIL nop retire_count: got %0d want 2", if1.retire_count);
    end
  endtask

  task automatic test_wrap();
    row_t t[5];
    logic [3:0] st;
    logic [17:0] o;
    // Preload the counter while the unit sits in IDLE with nothing retiring.
    dut.retire_q = 32'hFFFF_FFFF;
    t[0] = row(0, 1, 1, OP_J, S_IDLE,  0, 0, C_ZERO);
    t[1] = row(0, 0, 1, OP_J, S_FETCH, 0, 0, C_FETCH);
    t[2] = row(0, 0, 1, OP_J, S_DEC,   0, 0, C_DEC);
    t[3] = row(0, 0, 1, OP_J, S_JMP,   0, 1, C_JMP);
    t[4] = row(0, 0, 1, OP_J, S_IDLE,  0, 0, C_ZERO);
    for (int i = 0; i < 5; i++) begin
      drive_row(1'b0, t[i], st, o);
      vectors++;
      if (st !== t[i].st) begin
        miscompares++; $display("FAIL wrap[%0d] state: got %0d want %0d", i, st, t[i].st);
      end
      vectors++;
      if (o !== t[i].exp) begin
        miscompares++; $display("FAIL wrap[%0d] outputs: got %h want %h", i, o, t[i].exp);
      end
    end
    vectors++;
    if (if0.retire_count !== 32'd0) begin
      miscompares++; $display("FAIL wrap retire_count: got %h want 0", if0.retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_reset_priority();
    test_back_to_back();
    test_trap();
    test_nop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
